mem_io_unit: RTL and testbench
==============================

# mem_io_unit

Word-addressed memory and I/O unit directly downstream of the `cpu` bus (`address`, `datao`, `rw` in; `data` out). It holds a single-port data/instruction RAM and a small memory-mapped I/O window containing a transmit FIFO, a receive holding register and a status word. Reads are combinational so the CPU can latch fetched instructions and loads in the same cycle. Writes and I/O side effects commit on the clock edge, once per bus access.

## Interface
Parameters:
- `ADDR_BITS`, 10: RAM depth is 2^ADDR_BITS 32-bit words.
- `FIFO_DEPTH`, 8: TX FIFO entries. Must be a power of two, at least 2.
- `IO_BASE`, 32'hFFFF_0000: base word address of the I/O window.

Ports:
- `clock` in 1: single clock. All state updates on the posedge.
- `reset` in 1: asynchronous, active-low. Reset is asserted while low.
- `address` in 32: word address from the CPU.
- `datao` in 32: write data from the CPU.
- `rw` in 1: access type. 1 = read, 0 = write.
- `data` out 32: read data to the CPU.
- `tx_data` out 32: head entry of the TX FIFO.
- `tx_valid` out 1: TX FIFO is non-empty.
- `tx_ready` in 1: consumer accepts the head entry this cycle.
- `rx_data` in 32: incoming word.
- `rx_valid` in 1: `rx_data` is offered this cycle.
- `rx_ready` out 1: RX holding register is empty.

## Operation
Address decode:
- `address < 2^ADDR_BITS`: RAM, indexed by `address[ADDR_BITS-1:0]`.
- `address == IO_BASE`: TX push. Writes push `datao` into the FIFO. Reads return 0.
- `address == IO_BASE+1`: STATUS. Read bits:
  - [0] FIFO full
  - [1] FIFO empty
  - [2] tx_overflow (sticky)
  - [3] rx_overrun (sticky)
  - [4] rx_full
  - [15:8] FIFO count
  - all other bits 0.
  - Any write clears bits [2] and [3].
- `address == IO_BASE+2`: RX. Reads return the holding register and consume it. Writes are ignored.
- Any other address: reads return 0, writes are ignored.

Access edge detection:
- An access is a maximal run of consecutive cycles with the same `address` and `rw`.
- Side effects (FIFO push, STATUS clear, RX consume) fire only on the posedge ending the first cycle of an access.
- A registered copy of the previous `{address, rw}` plus a valid bit (cleared by reset) detects a new access.
- RAM writes are idempotent and commit on every posedge with `rw=0`.

TX FIFO:
- Circular buffer with pointers and a count of width log2(FIFO_DEPTH)+1.
- `tx_valid` = count != 0. `tx_data` = entry at the read pointer.
- Pop occurs when `tx_valid && tx_ready`.
- Push while full and no pop in the same cycle: data is dropped and tx_overflow is set.
- Push and pop in the same cycle while full: both are accepted and count is unchanged.
- Push and pop in the same cycle while empty: the push is accepted and no pop occurs, because `tx_valid` is 0.
- Pointers wrap modulo FIFO_DEPTH.

RX holding register:
- `rx_ready` = !rx_full.
- When `rx_valid` and !rx_full: capture `rx_data` and set rx_full.
- When `rx_valid` and rx_full: drop the word and set rx_overrun.
- An RX read consume clears rx_full.
- If a consume and an incoming `rx_valid` occur on the same edge, the new word is captured and rx_full stays 1. This is not an overrun.

## Timing
- `data` is combinational from `address`, `rw`, the RAM and the registers, with zero latency.
- A RAM write at edge N is visible to reads in cycle N+1.
- A TX push at edge N gives `tx_valid` = 1 in cycle N+1.
- A reset release followed by an edge gives normal operation from the first edge with `reset` high.
- Reset (low, asynchronous) forces:
  - FIFO empty: `tx_valid` = 0, count 0, pointers 0.
  - rx_full = 0, so `rx_ready` = 1.
  - Both sticky flags cleared.
  - Access-detect valid bit cleared.
  - RAM and FIFO storage contents are not reset.
  - `data` then reflects the decode of the current inputs.
- Reset asserted mid-access: the first cycle after release counts as a new access, so its side effect fires once.

## Test plan
- Write 32'hDEAD_BEEF to RAM word 5 with `rw=0` held 3 cycles. Then read word 5 → `data` = 32'hDEAD_BEEF in the cycle after the first write edge. Reading word 2^ADDR_BITS → 0.
- With `tx_ready`=0, push 1..9 as separate accesses (FIFO_DEPTH=8). STATUS then reads full=1, count=8, tx_overflow=1. Write STATUS → tx_overflow=0. Raise `tx_ready` → `tx_data` sequence 1..8, then `tx_valid`=0 and empty=1.
- Hold a push of 32'h55 with `rw=0` for 4 cycles → exactly one FIFO entry. Push 32'h66 as a new access → count 2.
- When full, push 32'hA while popping in the same cycle → count stays 8, no overflow, and 32'hA appears last in the drain order.
- Pulse `rx_valid` with 32'h12, then with 32'h34 → RX read returns 32'h12, rx_overrun=1. After the read, `rx_ready`=1. In a cycle with a consume read plus `rx_valid` 32'h77, the next RX read returns 32'h77 and no new overrun is set.
- Assert `reset` low mid-FIFO-drain with 3 entries → `tx_valid` drops to 0 immediately (asynchronous). After release, STATUS reads empty=1, count=0, flags=0.

Source files
------------

// File: rtl/mem_io_unit.sv
// mem_io_unit: word-addressed RAM plus a small memory-mapped I/O window
// (TX FIFO push port, STATUS word, RX holding register) sitting directly on
// the CPU bus. Reads are combinational; writes and I/O side effects commit
// on the rising clock edge, once per bus access.
module mem_io_unit #(
    parameter int          ADDR_BITS  = 10,
    parameter int          FIFO_DEPTH = 8,            // power of two, >= 2
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,      // asynchronous, active-low
    input  logic [31:0] address,
    input  logic [31:0] datao,
    input  logic        rw,         // 1 = read, 0 = write
    output logic [31:0] data,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int          RAM_WORDS = 1 << ADDR_BITS;
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] IO_TX     = IO_BASE;
    localparam logic [31:0] IO_STATUS = IO_BASE + 32'd1;
    localparam logic [31:0] IO_RX     = IO_BASE + 32'd2;

    // ------------------------------------------------------------------
    // Storage arrays and state registers
    // ------------------------------------------------------------------
    logic [31:0] ram_mem  [RAM_WORDS];
    logic [31:0] fifo_mem [FIFO_DEPTH];

    logic [31:0]      prev_addr_q,   prev_addr_d;
    logic             prev_rw_q,     prev_rw_d;
    logic             prev_valid_q,  prev_valid_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic             tx_overflow_q, tx_overflow_d;
    logic             rx_overrun_q,  rx_overrun_d;
    logic             rx_full_q,     rx_full_d;
    logic [31:0]      rx_hold_q,     rx_hold_d;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    logic                 is_ram;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 new_access;
    logic                 push_req;
    logic                 status_clr;
    logic                 rx_consume;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 push_ok;
    logic [31:0]          status_word;

    // Address decode and first-cycle-of-access detection.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        is_ram     = ((address >> ADDR_BITS) == 32'd0);
        ram_idx    = address[ADDR_BITS-1:0];
        new_access = !prev_valid_q || (address != prev_addr_q) || (rw != prev_rw_q);
        push_req   = new_access && !rw && (address == IO_TX);
        status_clr = new_access && !rw && (address == IO_STATUS);
        rx_consume = new_access &&  rw && (address == IO_RX);
    end

    // TX FIFO flags and the accept decision for push/pop.
    always_comb begin
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        tx_valid   = !fifo_empty;
        tx_data    = fifo_mem[rd_ptr_q];
        pop        = tx_valid && tx_ready;
        // A push into a full FIFO is still accepted when a pop frees a slot
        // on the same edge.
        push_ok    = push_req && (!fifo_full || pop);
        rx_ready   = !rx_full_q;
    end

    // Next-state for FIFO pointers, count and the TX overflow flag.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        tx_overflow_d = tx_overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (status_clr) begin
            tx_overflow_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            tx_overflow_d = 1'b1;
        end
    end

    // Next-state for the RX holding register and its overrun flag.
    always_comb begin
        rx_hold_d    = rx_hold_q;
        rx_full_d    = rx_full_q;
        rx_overrun_d = rx_overrun_q;

        if (status_clr) begin
            rx_overrun_d = 1'b0;
        end
        if (rx_consume) begin
            // Consume frees the register; a word arriving on the same edge
            // refills it immediately and is not an overrun.
            rx_full_d = rx_valid;
            if (rx_valid) begin
                rx_hold_d = rx_data;
            end
        end else if (rx_valid) begin
            if (!rx_full_q) begin
                rx_hold_d = rx_data;
                rx_full_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end
    end

    // Previous-access tracker: always tracks the current bus cycle.
    always_comb begin
        prev_addr_d  = address;
        prev_rw_d    = rw;
        prev_valid_d = 1'b1;
    end

    // STATUS word assembly and the combinational read-data mux.
    always_comb begin
        status_word       = '0;
        status_word[0]    = fifo_full;
        status_word[1]    = fifo_empty;
        status_word[2]    = tx_overflow_q;
        status_word[3]    = rx_overrun_q;
        status_word[4]    = rx_full_q;
        status_word[15:8] = 8'(count_q);

        data = '0;
        if (is_ram) begin
            data = ram_mem[ram_idx];
        end else if (address == IO_STATUS) begin
            data = status_word;
        end else if (address == IO_RX) begin
            data = rx_hold_q;
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, regardless of order.
        if (!reset) begin
            prev_addr_q   <= '0;
            prev_rw_q     <= 1'b0;
            prev_valid_q  <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tx_overflow_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            rx_full_q     <= 1'b0;
            rx_hold_q     <= '0;
        end else begin
            prev_addr_q   <= prev_addr_d;
            prev_rw_q     <= prev_rw_d;
            prev_valid_q  <= prev_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tx_overflow_q <= tx_overflow_d;
            rx_overrun_q  <= rx_overrun_d;
            rx_full_q     <= rx_full_d;
            rx_hold_q     <= rx_hold_d;
        end
    end

    // RAM and FIFO storage writes.
    always_ff @(posedge clock) begin
        // NOTE: the storage arrays are deliberately left out of reset; only
        // the pointers/count that say which entries are meaningful are reset,
        // which lets the arrays map onto plain RAM macros.
        if (!rw && is_ram) begin
            ram_mem[ram_idx] <= datao;
        end
        if (reset && push_ok) begin
            fifo_mem[wr_ptr_q] <= datao;
        end
    end

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed testbench for mem_io_unit: RAM access, TX FIFO fill/overflow/drain,
// access-edge detection, simultaneous push+pop, RX overrun and consume-refill,
// and asynchronous reset behaviour.
module tb_mem_io_unit;

    localparam logic [31:0] IO_BASE   = 32'hFFFF_0000;
    localparam logic [31:0] IO_TX     = IO_BASE;
    localparam logic [31:0] IO_STATUS = IO_BASE + 32'd1;
    localparam logic [31:0] IO_RX     = IO_BASE + 32'd2;
    localparam logic [31:0] IDLE_ADDR = 32'h0000_8000;   // unmapped

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] datao;
    logic        rw;
    logic [31:0] data;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int vectors     = 0;
    int miscompares = 0;

    mem_io_unit #(
        .ADDR_BITS  (10),
        .FIFO_DEPTH (8),
        .IO_BASE    (IO_BASE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .datao    (datao),
        .rw       (rw),
        .data     (data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; return just after it so outputs have settled.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        address = IDLE_ADDR;
        rw      = 1'b1;
        cyc();
    endtask

    // One-cycle TX push as its own access, followed by an idle cycle.
    task automatic push(input logic [31:0] v);
        address = IO_TX;
        datao   = v;
        rw      = 1'b0;
        cyc();
        idle();
    endtask

    task automatic write_status();
        address = IO_STATUS;
        datao   = 32'h0;
        rw      = 1'b0;
        cyc();
        idle();
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        rw      = 1'b1;
        #1;
        check(tag, data, exp);
    endtask

    logic [31:0] drain_exp [8];

    initial begin
        reset    = 1'b0;
        address  = IDLE_ADDR;
        datao    = 32'h0;
        rw       = 1'b1;
        tx_ready = 1'b0;
        rx_data  = 32'h0;
        rx_valid = 1'b0;

        // Reset state
        #12;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
        read_check("rst_status", IO_STATUS, 32'h0000_0002);
        read_check("unmapped_read", IDLE_ADDR, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        cyc();

        // RAM write held 3 cycles, visible after the first edge
        address = 32'd5;
        datao   = 32'hDEAD_BEEF;
        rw      = 1'b0;
        cyc();
        check("ram_after_first_edge", data, 32'hDEAD_BEEF);
        cyc();
        cyc();
        read_check("ram_read_w5", 32'd5, 32'hDEAD_BEEF);
        read_check("ram_oob_read", 32'd1024, 32'h0);
        idle();

        // Fill FIFO with 1..9; the ninth overflows
        for (int i = 1; i <= 9; i++) push(32'(i));
        read_check("status_full_ovf", IO_STATUS, 32'h0000_0805);
        read_check("tx_read_zero", IO_TX, 32'h0);
        write_status();
        read_check("status_ovf_clr", IO_STATUS, 32'h0000_0801);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain1_data", tx_data, 32'(i));
            cyc();
        end
        tx_ready = 1'b0;
        check("drain1_valid", {31'b0, tx_valid}, 32'd0);
        read_check("status_empty", IO_STATUS, 32'h0000_0002);

        // Held push: one entry only; then a fresh access adds a second
        address = IO_TX;
        datao   = 32'h55;
        rw      = 1'b0;
        repeat (4) cyc();
        idle();
        read_check("held_push_cnt1", IO_STATUS, 32'h0000_0100);
        push(32'h66);
        read_check("second_push_cnt2", IO_STATUS, 32'h0000_0200);
        check("head_55", tx_data, 32'h55);

        // Fill to 8, then push 0xA while popping
        for (int i = 1; i <= 6; i++) push(32'h100 + 32'(i));
        read_check("refill_full", IO_STATUS, 32'h0000_0801);
        address  = IO_TX;
        datao    = 32'hA;
        rw       = 1'b0;
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        idle();
        read_check("pushpop_full", IO_STATUS, 32'h0000_0801);
        drain_exp[0] = 32'h66;
        for (int i = 1; i <= 6; i++) drain_exp[i] = 32'h100 + 32'(i);
        drain_exp[7] = 32'hA;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain2_data", tx_data, drain_exp[i]);
            cyc();
        end
        tx_ready = 1'b0;
        check("drain2_valid", {31'b0, tx_valid}, 32'd0);

        // RX: capture, overrun, consume
        rx_valid = 1'b1;
        rx_data  = 32'h12;
        cyc();
        rx_valid = 1'b0;
        check("rx_ready_full", {31'b0, rx_ready}, 32'd0);
        rx_valid = 1'b1;
        rx_data  = 32'h34;
        cyc();
        rx_valid = 1'b0;
        read_check("status_rx_ovr", IO_STATUS, 32'h0000_001A);
        read_check("rx_read_12", IO_RX, 32'h12);
        cyc();
        idle();
        check("rx_ready_after_read", {31'b0, rx_ready}, 32'd1);
        read_check("status_after_consume", IO_STATUS, 32'h0000_000A);
        write_status();
        rx_valid = 1'b1;
        rx_data  = 32'h50;
        cyc();
        rx_valid = 1'b0;
        read_check("rx_read_50", IO_RX, 32'h50);
        rx_valid = 1'b1;
        rx_data  = 32'h77;
        cyc();
        rx_valid = 1'b0;
        idle();
        read_check("status_refill", IO_STATUS, 32'h0000_0012);
        read_check("rx_read_77", IO_RX, 32'h77);
        cyc();
        idle();
        read_check("status_rx_empty", IO_STATUS, 32'h0000_0002);

        // Async reset mid-drain with 3 entries
        push(32'h1);
        push(32'h2);
        push(32'h3);
        tx_ready = 1'b1;
        #1;
        check("pre_rst_head", tx_data, 32'h1);
        cyc();
        check("pre_rst_head2", tx_data, 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        #3;
        reset    = 1'b1;
        tx_ready = 1'b0;
        read_check("post_rst_status", IO_STATUS, 32'h0000_0002);
        cyc();

        // Reset in the middle of a held push: fires once after release
        address = IO_TX;
        datao   = 32'hBB;
        rw      = 1'b0;
        cyc();
        #2;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        repeat (3) cyc();
        idle();
        read_check("rst_mid_access_cnt", IO_STATUS, 32'h0000_0100);
        check("rst_mid_access_data", tx_data, 32'hBB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
